// File: rtl/div_unit.sv
// Multi-cycle 32-bit integer divider (DIV/DIVU/REM/REMU) for the EX stage.
// Restoring radix-2 on operand magnitudes, one quotient bit per cycle, then sign fix-up.
module div_unit (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [1:0]  op,
    input  logic [31:0] SrcA,
    input  logic [31:0] SrcB,
    input  logic        flush,
    output logic        busy,
    output logic        done,
    output logic [31:0] Result
);

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t      state_q, state_d;
    logic [32:0] rem_q, rem_d;
    logic [31:0] quo_q, quo_d;
    logic [31:0] dsr_q, dsr_d;
    logic [31:0] result_q, result_d;
    logic [5:0]  cnt_q, cnt_d;
    logic        rem_op_q, rem_op_d;
    logic        neg_q, neg_d;

    logic        sign_a, sign_b;
    logic [31:0] mag_a, mag_b;
    logic        div_zero, sgn_ovf, accept;
    logic [33:0] rem_sh, diff;
    logic [31:0] sel;

    always_comb begin
        sign_a   = ~op[0] & SrcA[31];
        sign_b   = ~op[0] & SrcB[31];
        mag_a    = sign_a ? -SrcA : SrcA;
        mag_b    = sign_b ? -SrcB : SrcB;
        div_zero = (SrcB == 32'd0);
        sgn_ovf  = ~op[0] & (SrcA == 32'h8000_0000) & (SrcB == 32'hFFFF_FFFF);
        accept   = (state_q == IDLE) & start & ~flush;
    end

    // State register and datapath flops share one async-reset process.
    // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= IDLE;
            rem_q    <= '0;
            quo_q    <= '0;
            dsr_q    <= '0;
            result_q <= '0;
            cnt_q    <= '0;
            rem_op_q <= 1'b0;
            neg_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            rem_q    <= rem_d;
            quo_q    <= quo_d;
            dsr_q    <= dsr_d;
            result_q <= result_d;
            cnt_q    <= cnt_d;
            rem_op_q <= rem_op_d;
            neg_q    <= neg_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (accept) state_d = (div_zero | sgn_ovf) ? DONE : CALC;
            CALC: begin
                if (flush)                state_d = IDLE;
                else if (cnt_q == 6'd32)  state_d = DONE;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Datapath: capture, iterate, sign-correct.
    // NOTE: every variable gets a hold default up front so no path infers a latch.
    always_comb begin
        rem_d    = rem_q;
        quo_d    = quo_q;
        dsr_d    = dsr_q;
        result_d = result_q;
        cnt_d    = cnt_q;
        rem_op_d = rem_op_q;
        neg_d    = neg_q;
        rem_sh   = {rem_q, quo_q[31]};
        diff     = rem_sh - {2'b00, dsr_q};
        sel      = rem_op_q ? rem_q[31:0] : quo_q;

        if (accept) begin
            rem_d    = '0;
            quo_d    = mag_a;
            dsr_d    = mag_b;
            cnt_d    = '0;
            rem_op_d = op[1];
            neg_d    = op[1] ? sign_a : (sign_a ^ sign_b);
            if (div_zero)     result_d = op[1] ? SrcA : 32'hFFFF_FFFF;
            else if (sgn_ovf) result_d = op[1] ? 32'd0 : 32'h8000_0000;
        end else if (state_q == CALC && !flush) begin
            if (cnt_q != 6'd32) begin
                rem_d = diff[33] ? rem_sh[32:0] : diff[32:0];
                quo_d = {quo_q[30:0], ~diff[33]};
                cnt_d = cnt_q + 6'd1;
            end else begin
                result_d = neg_q ? -sel : sel;
            end
        end
    end

    // Outputs.
    always_comb begin
        busy   = (state_q != IDLE);
        done   = (state_q == DONE);
        Result = result_q;
    end

endmodule

// File: tb/tb_div_unit.sv
// Self-checking bench for div_unit: directed corner cases plus randomized ops,
// scored against an arithmetic reference model through an expected-result queue.
module tb_div_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [1:0]  op = 2'b00;
    logic [31:0] SrcA = '0;
    logic [31:0] SrcB = '0;
    logic        flush = 1'b0;
    logic        busy, done;
    logic [31:0] Result;

    int          n_checks = 0;
    int          n_pass = 0;
    int          done_cnt = 0;
    logic [31:0] exp_q[$];
    logic [31:0] last_result = '0;

    div_unit dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .op     (op),
        .SrcA   (SrcA),
        .SrcB   (SrcB),
        .flush  (flush),
        .busy   (busy),
        .done   (done),
        .Result (Result)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    // Reference: plain integer arithmetic plus the defined special cases.
    function automatic logic [31:0] ref_model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        int sa, sb;
        if (b == 32'd0) return o[1] ? a : 32'hFFFF_FFFF;
        if (!o[0]) begin
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return o[1] ? 32'd0 : 32'h8000_0000;
            sa = a;
            sb = b;
            return o[1] ? 32'(sa % sb) : 32'(sa / sb);
        end
        return o[1] ? a % b : a / b;
    endfunction

    function automatic int exp_busy(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        if (b == 32'd0) return 1;
        if (!o[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
        return 34;
    endfunction

    // Monitor: every done pulse must match the oldest expected result.
    initial begin
        forever begin
            @(negedge clk);
            if (done) begin
                done_cnt++;
                if (exp_q.size() == 0) check("spurious_done", 32'd1, 32'd0);
                else check("result", Result, exp_q.pop_front());
            end
        end
    end

    // Issue one op from a negedge with the block idle; scramble inputs while busy,
    // and hold start high in the DONE cycle to confirm it is not accepted.
    task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        int cycles;
        int done_before;
        logic [31:0] e;
        e = ref_model(o, a, b);
        done_before = done_cnt;
        op = o;
        SrcA = a;
        SrcB = b;
        start = 1'b1;
        exp_q.push_back(e);
        @(posedge clk);
        cycles = 0;
        @(negedge clk);
        while (busy && cycles < 100) begin
            cycles++;
            start = done ? 1'b1 : 1'($urandom_range(0, 1));
            op = 2'($urandom);
            SrcA = $urandom;
            SrcB = $urandom;
            @(negedge clk);
        end
        start = 1'b0;
        check("busy_cycles", 32'(cycles), 32'(exp_busy(o, a, b)));
        check("done_pulses", 32'(done_cnt - done_before), 32'd1);
        check("result_hold", Result, e);
        last_result = e;
    endtask

    initial begin
        logic [1:0]  ro;
        logic [31:0] ra, rb;
        int          done_before;

        #1 rst = 1'b0;
        #1;
        check("reset_busy", {31'd0, busy}, 32'd0);
        check("reset_done", {31'd0, done}, 32'd0);
        check("reset_result", Result, 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b1;

        // First edge after release must accept.
        run_op(2'b01, 32'd100, 32'd7);
        run_op(2'b11, 32'd100, 32'd7);
        run_op(2'b00, 32'hFFFF_FFF9, 32'd2);
        run_op(2'b10, 32'hFFFF_FFF9, 32'd2);
        run_op(2'b00, 32'd7, 32'hFFFF_FFFE);
        run_op(2'b00, 32'd5, 32'd0);
        run_op(2'b11, 32'd5, 32'd0);
        run_op(2'b00, 32'h8000_0000, 32'hFFFF_FFFF);
        run_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF);
        run_op(2'b01, 32'h8000_0000, 32'hFFFF_FFFF);
        run_op(2'b10, 32'h8000_0001, 32'd3);
        run_op(2'b01, 32'hFFFF_FFFF, 32'd1);

        // Flush at E10: immediate idle, no done, Result untouched.
        done_before = done_cnt;
        op = 2'b01; SrcA = 32'd100; SrcB = 32'd7; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        check("flush_busy", {31'd0, busy}, 32'd0);
        check("flush_done", {31'd0, done}, 32'd0);
        check("flush_result", Result, last_result);
        repeat (40) @(negedge clk);
        check("flush_no_done", 32'(done_cnt - done_before), 32'd0);

        // Flush in IDLE beats start.
        flush = 1'b1; start = 1'b1;
        @(negedge clk);
        flush = 1'b0; start = 1'b0;
        check("flush_idle_busy", {31'd0, busy}, 32'd0);

        // Async reset mid-operation.
        done_before = done_cnt;
        op = 2'b01; SrcA = 32'd100; SrcB = 32'd7; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (14) @(negedge clk);
        #2 rst = 1'b0;
        #1;
        check("async_busy", {31'd0, busy}, 32'd0);
        check("async_done", {31'd0, done}, 32'd0);
        check("async_result", Result, 32'd0);
        @(negedge clk);
        rst = 1'b1;
        repeat (40) @(negedge clk);
        check("reset_no_done", 32'(done_cnt - done_before), 32'd0);
        run_op(2'b01, 32'd9, 32'd3);

        // Randomized ops with occasional corner operands.
        for (int i = 0; i < 40; i++) begin
            ro = 2'($urandom);
            ra = $urandom;
            rb = $urandom;
            case ($urandom_range(0, 5))
                0: rb = 32'd0;
                1: rb = 32'($urandom_range(1, 15));
                2: begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
                3: rb = -32'($urandom_range(1, 15));
                default: ;
            endcase
            run_op(ro, ra, rb);
        end

        check("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
